vco_phase_cic_dec: RTL and testbench

- Digital back end of the VCO-based ADC; sits directly downstream of the ring-oscillator VCO (`vco_w6_r100`) and consumes its PHASE_WIDTH-bit phase bus `p`.
- Datapath: synchronises `p`, decodes the Johnson-coded ring phase to an integer, and first-differences it into a per-clock frequency count. A 2nd-order CIC then decimates by 2^OSR_LOG2 and emits one signed sample per decimation period with a valid strobe.
- Also drives the VCO's active-low enable.

---
 rtl/vco_phase_cic_dec.sv | 126 ++++++++++++
 tb/tb_vco_phase_cic_dec.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vco_phase_cic_dec.sv
// VCO-ADC back end: synchronises the ring phase, turns it into a per-clock frequency count,
// and decimates that count with a 2nd-order CIC. Also drives the VCO's active-low enable.
`timescale 1ns/1ps
module vco_phase_cic_dec #(
  parameter int unsigned PHASE_WIDTH = 11,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OSR_LOG2    = 9,
  parameter int unsigned OUT_WIDTH   = 24
) (
`ifdef USE_POWER_PINS
  inout  wire                   vccd2,
  inout  wire                   vssd2,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] p,
  output logic                   vco_enb,
  output logic [OUT_WIDTH-1:0]   data,
  output logic                   valid,
  output logic                   dec_err
);
  localparam int unsigned M  = 2 * PHASE_WIDTH;
  localparam int unsigned SW = $clog2(M);
  localparam int unsigned CW = $clog2(PHASE_WIDTH + 1);

  logic [PHASE_WIDTH-1:0] sync [SYNC_STAGES];
  logic [SYNC_STAGES:0]   sv;
  logic [PHASE_WIDTH-1:0] ps;
  logic [SW-1:0]          s, s_last, s_dec, d, d_next;
  logic [CW-1:0]          ones, trans;
  logic                   illegal, prime, en_q;
  logic [OUT_WIDTH-1:0]   i1, i2, i2_z, c1_z, c1, c2;
  logic [OSR_LOG2-1:0]    cnt;
  logic [1:0]             warm;

  assign ps = sync[SYNC_STAGES-1];

  // Johnson-code decode, adjacent-transition legality check and modulo-M difference
  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) ones = ones + CW'(ps[i]);
    for (int i = 0; i < PHASE_WIDTH - 1; i++) trans = trans + CW'(ps[i] ^ ps[i+1]);
    if (ps[0])          s_dec = SW'(ones);
    else if (ps == '0)  s_dec = '0;
    else                s_dec = SW'(M - 32'(ones));
    illegal = trans > CW'(1);
    if (s >= s_last) d_next = s - s_last;
    else             d_next = SW'(32'(s) + M - 32'(s_last));
    c1 = i2 - i2_z;
    c2 = c1 - c1_z;
  end

  // sv tracks which pipeline stages hold data captured since enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      sv      <= '0;
      s       <= '0;
      s_last  <= '0;
      d       <= '0;
      prime   <= 1'b0;
      i1      <= '0;
      i2      <= '0;
      i2_z    <= '0;
      c1_z    <= '0;
      cnt     <= '0;
      warm    <= '0;
      en_q    <= 1'b0;
      vco_enb <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      dec_err <= 1'b0;
    end else begin
      vco_enb <= ~en;
      en_q    <= en;
      valid   <= 1'b0;
      if (!en) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
        sv     <= '0;
        s      <= '0;
        s_last <= '0;
        d      <= '0;
        prime  <= 1'b0;
        i1     <= '0;
        i2     <= '0;
        i2_z   <= '0;
        c1_z   <= '0;
        cnt    <= '0;
        warm   <= '0;
      end else begin
        sync[0] <= p;
        for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        sv <= {sv[SYNC_STAGES-1:0], 1'b1};
        s  <= s_dec;
        // first valid s only primes the differencer; its d is forced to zero
        if (sv[SYNC_STAGES]) begin
          s_last <= s;
          prime  <= 1'b1;
          d      <= prime ? d_next : '0;
        end else begin
          d <= '0;
        end
        i1 <= i1 + OUT_WIDTH'(d);
        i2 <= i2 + i1;
        if (prime) begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            i2_z <= i2;
            c1_z <= c1;
            if (warm == 2'd2) begin
              valid <= 1'b1;
              data  <= c2;
            end else begin
              warm <= warm + 2'd1;
            end
          end
        end
      end
      if (en && !en_q)                        dec_err <= 1'b0;
      else if (en && sv[SYNC_STAGES-1] && illegal) dec_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vco_phase_cic_dec.sv
// Bench for vco_phase_cic_dec: directed decode/difference/error checks plus randomised
// phase streams scored against a closed-form CIC reference (R=4 and R=512 instances).
`timescale 1ns/1ps
module tb_vco_phase_cic_dec;
  localparam int N  = 11;
  localparam int M  = 2 * N;
  localparam int OW = 24;
  localparam int R4 = 4;
  localparam int R9 = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b1;
  logic [N-1:0]  p   = '0;
  logic          vco_enb4, valid4, dec_err4;
  logic          vco_enb9, valid9, dec_err9;
  logic [OW-1:0] data4, data9;

  int     total = 0;
  int     bad   = 0;
  longint i2q[$];
  longint last4 = 0;
  longint last9 = 0;

  always #10 clk = ~clk;

  vco_phase_cic_dec #(.PHASE_WIDTH(N), .SYNC_STAGES(2), .OSR_LOG2(2), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .p(p),
    .vco_enb(vco_enb4), .data(data4), .valid(valid4), .dec_err(dec_err4));

  vco_phase_cic_dec dut9 (
    .clk(clk), .rst(rst), .en(en), .p(p),
    .vco_enb(vco_enb9), .data(data9), .valid(valid9), .dec_err(dec_err9));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Johnson pattern for ring state k (0..M-1)
  function automatic logic [N-1:0] pat(input int k);
    if (k <= N) return N'((1 << k) - 1);
    return N'(((1 << (M - k)) - 1) << (N - (M - k)));
  endfunction

  // Second integrator sampled at the end of decimation period q (zero before the first)
  function automatic longint xv(input int rr, input int q);
    return (q >= 1) ? i2q[q*rr-1] : 64'sd0;
  endfunction

  function automatic longint cic_out(input int rr, input int n);
    return xv(rr, n) - 2 * xv(rr, n - 1) + xv(rr, n - 2);
  endfunction

  task automatic cic_cycle(input string tag, input int c, input int rr, input logic v,
                           input logic [OW-1:0] dat, inout longint last);
    bit ev;
    ev = (c >= 3 + 3 * rr) && ((c - 3) % rr == 0);
    check({tag, "_valid"}, 64'(v), 64'(ev));
    if (ev) begin
      last = cic_out(rr, (c - 3) / rr);
      check({tag, "_data"}, 64'(dat), 64'(OW'(last)));
    end
  endtask

  // Enable, play len+1 phase states (step<0: random jumps), score every cycle, then disable.
  task automatic run_stream(input int len, input int step);
    int     ks[$];
    longint acc1;
    ks.push_back(int'($urandom_range(M - 1, 0)));
    for (int j = 1; j <= len; j++)
      ks.push_back(step < 0 ? int'($urandom_range(M - 1, 0)) : (ks[j-1] + step) % M);
    i2q.delete();
    i2q.push_back(0);
    acc1 = 0;
    for (int m = 1; m <= len; m++) begin
      i2q.push_back(i2q[m-1] + acc1);
      acc1 = acc1 + ((m >= 2) ? longint'((ks[m-1] - ks[m-2] + M) % M) : 64'sd0);
    end
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    p  = pat(ks[0]);
    for (int c = 0; c < len; c++) begin
      tick();
      cic_cycle("r4", c, R4, valid4, data4, last4);
      cic_cycle("r512", c, R9, valid9, data9, last9);
      p = pat(ks[c+1]);
    end
    check("stream_dec_err", 64'(dec_err4), 64'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("off_valid4", 64'(valid4), 64'd0);
      check("off_valid9", 64'(valid9), 64'd0);
      check("off_hold4", 64'(data4), 64'(OW'(last4)));
      check("off_hold9", 64'(data9), 64'(OW'(last9)));
    end
  endtask

  initial begin
    logic [N-1:0] dec_p [6];
    int           dec_s [6];
    logic [N-1:0] bad_p;
    dec_p = '{11'h000, 11'h001, 11'h3FF, 11'h7FF, 11'h7FE, 11'h400};
    dec_s = '{0, 1, 10, 11, 12, 21};
    bad_p = 11'h005;

    // reset held with en=1
    repeat (3) tick();
    check("rst_vco_enb", 64'(vco_enb4), 64'd1);
    check("rst_vco_enb9", 64'(vco_enb9), 64'd1);
    check("rst_valid", 64'(valid4), 64'd0);
    check("rst_data", 64'(data4), 64'd0);
    check("rst_data9", 64'(data9), 64'd0);
    check("rst_dec_err", 64'(dec_err4), 64'd0);
    rst = 1'b1;
    tick();
    check("vco_enb_on", 64'(vco_enb4), 64'd0);
    en = 1'b0;
    tick();
    check("vco_enb_off", 64'(vco_enb4), 64'd1);
    en = 1'b1;

    // static decode table
    for (int i = 0; i < 6; i++) begin
      p = dec_p[i];
      repeat (3) tick();
      check($sformatf("decode_%0h", dec_p[i]), 64'(dut.s), 64'(dec_s[i]));
    end
    check("decode_dec_err", 64'(dec_err4), 64'd0);

    // modulo-M difference across the wrap point
    p = pat(20);
    repeat (4) tick();
    p = pat(3);
    repeat (4) tick();
    check("diff_20_3", 64'(dut.d), 64'd5);
    p = pat(21);
    repeat (4) tick();
    check("diff_3_21", 64'(dut.d), 64'd18);
    p = pat(0);
    repeat (4) tick();
    check("diff_21_0", 64'(dut.d), 64'd1);
    for (int i = 1; i <= 10; i++) begin
      p = pat((3 * i) % M);
      tick();
      if (i >= 4) check($sformatf("diff_step3_%0d", i), 64'(dut.d), 64'd3);
    end

    // sticky illegal-pattern flag, cleared by re-enable
    p = bad_p;
    tick();
    p = pat(5);
    repeat (3) tick();
    check("dec_err_set", 64'(dec_err4), 64'd1);
    check("dec_err_set9", 64'(dec_err9), 64'd1);
    repeat (5) tick();
    check("dec_err_sticky", 64'(dec_err4), 64'd1);
    en = 1'b0;
    tick();
    check("dec_err_hold_off", 64'(dec_err4), 64'd1);
    en = 1'b1;
    tick();
    check("dec_err_clear", 64'(dec_err4), 64'd0);
    repeat (4) tick();
    check("dec_err_stays_clear", 64'(dec_err4), 64'd0);

    // steady step of 3: 48 at R=4, 786432 at R=512
    run_stream(2100, 3);
    check("steady_r4", 64'(data4), 64'd48);
    check("steady_r512", 64'(data9), 64'd786432);
    // drop en at count 2 of a period, then re-enable with random phase jumps
    run_stream(18, 3);
    run_stream(80, -1);
    run_stream(1600, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
